// File: rtl/envelope_pwm_shaper.sv
// ADSR envelope applied to a square-wave tone by PWM gating.
// Drives complementary speaker outputs; single clock domain.
module envelope_pwm_shaper #(
    parameter int unsigned LEVEL_W       = 8,
    parameter int unsigned ENV_DIV       = 64,
    parameter int unsigned ATTACK_STEP   = 16,
    parameter int unsigned DECAY_STEP    = 1,
    parameter int unsigned SUSTAIN_LEVEL = 96,
    parameter int unsigned RELEASE_STEP  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tone_in,
    input  logic               gate,
    output logic               pwm_out,
    output logic               pwm_out_n,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         state,
    output logic               busy
);

    localparam int unsigned PW = $clog2(ENV_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(ENV_DIV - 1);
    localparam logic [LEVEL_W-1:0] MAX_L = '1;
    localparam logic [LEVEL_W-1:0] SUS_L = LEVEL_W'(SUSTAIN_LEVEL);
    localparam logic [LEVEL_W:0] ATT_E = (LEVEL_W+1)'(ATTACK_STEP);
    localparam logic [LEVEL_W:0] DEC_E = (LEVEL_W+1)'(DECAY_STEP);
    localparam logic [LEVEL_W:0] REL_E = (LEVEL_W+1)'(RELEASE_STEP);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_e;

    state_e             state_q;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] pwm_cnt_q;
    logic [PW-1:0]      presc_q;
    logic               gate_q;
    logic               pwm_q;
    logic               busy_q;

    logic               rise, fall, env_tick;
    logic [LEVEL_W:0]   att_sum, dec_raw, rel_raw;
    logic [LEVEL_W-1:0] att_d, dec_d, rel_d;

    assign rise     = gate & ~gate_q;
    assign fall     = ~gate & gate_q;
    assign env_tick = (presc_q == PRESC_LAST) & ~rise;

    // Extra top bit flags overflow/borrow so results saturate, never wrap
    assign att_sum = {1'b0, level_q} + ATT_E;
    assign dec_raw = {1'b0, level_q} - DEC_E;
    assign rel_raw = {1'b0, level_q} - REL_E;

    always_comb begin
        att_d = att_sum[LEVEL_W] ? MAX_L : att_sum[LEVEL_W-1:0];
        dec_d = dec_raw[LEVEL_W] ? '0 : dec_raw[LEVEL_W-1:0];
        if (dec_d < SUS_L) dec_d = SUS_L;
        rel_d = rel_raw[LEVEL_W] ? '0 : rel_raw[LEVEL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            level_q   <= '0;
            pwm_cnt_q <= '0;
            presc_q   <= '0;
            gate_q    <= 1'b0;
            pwm_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            gate_q    <= gate;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_q     <= tone_in & (pwm_cnt_q < level_q);
            if (rise || presc_q == PRESC_LAST) presc_q <= '0;
            else presc_q <= presc_q + 1'b1;

            if (rise) begin
                state_q <= ATTACK;
                busy_q  <= 1'b1;
            end else if (fall && (state_q == ATTACK ||
                                  state_q == DECAY ||
                                  state_q == SUSTAIN)) begin
                state_q <= RELEASE;
            end else if (env_tick) begin
                case (state_q)
                    ATTACK: begin
                        level_q <= att_d;
                        if (att_d == MAX_L) state_q <= DECAY;
                    end
                    DECAY: begin
                        level_q <= dec_d;
                        if (dec_d == SUS_L) state_q <= SUSTAIN;
                    end
                    RELEASE: begin
                        level_q <= rel_d;
                        if (rel_d == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pwm_out   = pwm_q;
    assign pwm_out_n = ~pwm_q;
    assign level     = level_q;
    assign state     = state_q;
    assign busy      = busy_q;

endmodule
